// File: rtl/regfile_param.sv
// regfile_param: DEPTH x WIDTH register file with two combinational read
// ports, a delayed (w_en) and an immediate (mem) write path, optional
// write-through forwarding, optional hardwired-zero register 0 and a
// sequenced clear sweep that zeroes one register per cycle.
module regfile_param #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] dest,
   input  logic [ADDR_W-1:0] src0,
   input  logic [ADDR_W-1:0] src1,
   input  logic [WIDTH-1:0]  w_in,
   input  logic              w_en,
   input  logic              mem,
   input  logic              clr,
   output logic [WIDTH-1:0]  op0,
   output logic [WIDTH-1:0]  op1,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   localparam logic [ADDR_W-1:0] LAST = '1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_w_en_q;
   logic [WIDTH-1:0]  r_regs [DEPTH];

   logic w_wr;
   logic w_dest_ok;
   logic w_wr_eff;

   // Read mux: stored value, zero-register mask, write-through, reset mask.
   // Reset forces zero so a bypassed w_in can never leak out during reset.
   function automatic logic [WIDTH-1:0] read_port(
      input logic [ADDR_W-1:0] src,
      input logic [WIDTH-1:0]  stored,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [WIDTH-1:0]  wr_data,
      input logic              wr_eff,
      input logic              in_reset
   );
      logic [WIDTH-1:0] v;
      v = stored;
      if ((ZERO_REG != 0) && (src == '0)) begin
         v = '0;
      end
      if ((BYPASS != 0) && wr_eff && (src == wr_addr)) begin
         v = wr_data;
      end
      if (in_reset) begin
         v = '0;
      end
      return v;
   endfunction

   // Writes happen only in IDLE and lose to a simultaneous clear request.
   assign w_wr      = (r_state == S_IDLE) & ~clr & (r_w_en_q | mem);
   // A write aimed at a hardwired-zero register 0 is dropped entirely,
   // which also keeps it out of the forwarding path.
   assign w_dest_ok = !((ZERO_REG != 0) && (dest == '0));
   assign w_wr_eff  = w_wr & w_dest_ok;

   assign busy = (r_state == S_CLEAR);

   assign op0 = read_port(src0, r_regs[src0], dest, w_in, w_wr_eff, reset);
   assign op1 = read_port(src1, r_regs[src1], dest, w_in, w_wr_eff, reset);

   // Delayed write request: sampled every cycle regardless of state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_w_en_q <= 1'b0;
      end else begin
         r_w_en_q <= w_en;
      end
   end

   // Clear-sweep FSM: IDLE -> CLEAR on clr, one address per cycle, exit
   // after the last address so the counter wraps back to zero on exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clr) begin
                  r_state <= S_CLEAR;
                  r_cnt   <= '0;
               end
            end
            S_CLEAR: begin
               r_cnt <= r_cnt + ADDR_W'(1);
               if (r_cnt == LAST) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Register array: sweep clears reg[cnt], otherwise at most one write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (r_state == S_CLEAR) begin
         r_regs[r_cnt] <= '0;
      end else if (w_wr_eff) begin
         r_regs[dest] <= w_in;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param. Three instances share one stimulus
// stream: default (BYPASS=1, ZERO_REG=0), no-bypass, and zero-register.
module tb_regfile_param;

   logic        clk = 1'b1;
   logic        reset;
   logic [2:0]  dest, src0, src1;
   logic [15:0] w_in;
   logic        w_en, mem, clr;

   logic [15:0] op0, op1, op0_nb, op1_nb, op0_z, op1_z;
   logic        busy, busy_nb, busy_z;

   localparam int S_OP0    = 0;
   localparam int S_OP1    = 1;
   localparam int S_BUSY   = 2;
   localparam int S_OP0_NB = 3;
   localparam int S_OP0_Z  = 4;

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   regfile_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut (
      .clk(clk), .reset(reset), .dest(dest), .src0(src0), .src1(src1),
      .w_in(w_in), .w_en(w_en), .mem(mem), .clr(clr),
      .op0(op0), .op1(op1), .busy(busy)
   );

   regfile_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_nb (
      .clk(clk), .reset(reset), .dest(dest), .src0(src0), .src1(src1),
      .w_in(w_in), .w_en(w_en), .mem(mem), .clr(clr),
      .op0(op0_nb), .op1(op1_nb), .busy(busy_nb)
   );

   regfile_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
      .clk(clk), .reset(reset), .dest(dest), .src0(src0), .src1(src1),
      .w_in(w_in), .w_en(w_en), .mem(mem), .clr(clr),
      .op0(op0_z), .op1(op1_z), .busy(busy_z)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] sig(input int sel);
      case (sel)
         S_OP0:    return op0;
         S_OP1:    return op1;
         S_BUSY:   return {15'd0, busy};
         S_OP0_NB: return op0_nb;
         S_OP0_Z:  return op0_z;
         default:  return 16'hxxxx;
      endcase
   endfunction

   task automatic expect_now(input int sel, input logic [15:0] exp, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop every expectation due in this cycle and compare it.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         m_e = sb.pop_front();
         n_cmp++;
         if (m_e.cyc != cyc) begin
            n_bad++;
            $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)",
                     m_e.name, m_e.cyc, cyc);
         end else if (sig(m_e.sel) !== m_e.exp) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got %h expected %h",
                     m_e.name, cyc, sig(m_e.sel), m_e.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; dest = '0; src0 = '0; src1 = '0; w_in = '0;
      w_en = 1'b0; mem = 1'b0; clr = 1'b0;
      step();

      // Reset held: write attempt with matching src must read 0, busy 0
      mem = 1'b1; dest = 3'd5; w_in = 16'hFFFF; src0 = 3'd5; src1 = 3'd5;
      expect_now(S_OP0,    16'h0000, "rst_op0_masked");
      expect_now(S_OP1,    16'h0000, "rst_op1_masked");
      expect_now(S_BUSY,   16'h0000, "rst_busy");
      expect_now(S_OP0_NB, 16'h0000, "rst_op0_nb");
      step();
      reset = 1'b0; mem = 1'b0;
      expect_now(S_OP0, 16'h0000, "rst_no_write");

      // Delayed write: w_en now, dest/w_in next cycle
      step();
      dest = 3'd7; w_in = 16'h1111; w_en = 1'b1; src1 = 3'd7;
      expect_now(S_OP1, 16'h0000, "dly_not_early");
      step();
      w_en = 1'b0; dest = 3'd5; w_in = 16'hBEEF; src0 = 3'd5;
      expect_now(S_OP0,    16'hBEEF, "dly_bypass");
      expect_now(S_OP0_NB, 16'h0000, "dly_nb_old");
      step();
      dest = 3'd0; w_in = 16'h0000; src0 = 3'd5; src1 = 3'd7;
      expect_now(S_OP0,    16'hBEEF, "dly_read");
      expect_now(S_OP0_NB, 16'hBEEF, "dly_nb_read");
      expect_now(S_OP1,    16'h0000, "dly_reg7_untouched");

      // Immediate mem write with same-cycle forwarding on both ports
      step();
      mem = 1'b1; dest = 3'd3; w_in = 16'h1234; src0 = 3'd3; src1 = 3'd3;
      expect_now(S_OP0,    16'h1234, "mem_bypass_op0");
      expect_now(S_OP1,    16'h1234, "mem_bypass_op1");
      expect_now(S_OP0_NB, 16'h0000, "mem_nb_same_cycle");
      step();
      mem = 1'b0;
      expect_now(S_OP0_NB, 16'h1234, "mem_nb_next");

      // Register 0 write: hardwired zero vs ordinary register
      step();
      mem = 1'b1; dest = 3'd0; w_in = 16'hFFFF; src0 = 3'd0;
      expect_now(S_OP0_Z, 16'h0000, "zero_same_cycle");
      expect_now(S_OP0,   16'hFFFF, "nozero_bypass");
      step();
      mem = 1'b0;
      expect_now(S_OP0_Z, 16'h0000, "zero_next_cycle");
      expect_now(S_OP0,   16'hFFFF, "nozero_stored");

      // Preload registers with 1..8
      for (int k = 0; k < 8; k++) begin
         step();
         mem = 1'b1; dest = 3'(k); w_in = 16'(k + 1);
      end
      step();
      mem = 1'b0; clr = 1'b1; src0 = 3'd6;
      expect_now(S_OP0, 16'h0007, "pre_clr_r6");

      // Sweep: mem write at j=2, clr at j=4 ignored, w_en at j=7
      for (int j = 0; j < 8; j++) begin
         step();
         clr  = (j == 4);
         mem  = (j == 2);
         dest = (j == 2) ? 3'd6 : 3'd0;
         w_in = 16'h5555;
         w_en = (j == 7);
         src1 = 3'(j);
         expect_now(S_BUSY, 16'h0001, $sformatf("clr_busy_%0d", j));
         expect_now(S_OP1,  16'(j + 1), $sformatf("clr_unswept_%0d", j));
         if (j == 0 || j == 2 || j == 3) begin
            src0 = 3'd6;
            expect_now(S_OP0, 16'h0007, $sformatf("clr_r6_live_%0d", j));
         end else begin
            src0 = 3'(j - 1);
            expect_now(S_OP0, 16'h0000, $sformatf("clr_swept_%0d", j));
         end
      end
      step();
      w_en = 1'b0; clr = 1'b0; mem = 1'b0; dest = 3'd4; w_in = 16'h4444;
      src0 = 3'd4; src1 = 3'd0;
      expect_now(S_BUSY, 16'h0000, "clr_done");
      expect_now(S_OP0,  16'h4444, "wen_final_bypass");
      expect_now(S_OP1,  16'h0000, "clr_r0_zero");
      step();
      dest = 3'd0; w_in = 16'h0000;
      for (int k = 0; k < 8; k++) begin
         src0 = 3'(k);
         expect_now(S_OP0, (k == 4) ? 16'h4444 : 16'h0000, $sformatf("post_clr_r%0d", k));
         step();
      end

      // clr and mem write in the same cycle: clear wins
      mem = 1'b1; dest = 3'd2; w_in = 16'h2222;
      step();
      clr = 1'b1; mem = 1'b1; dest = 3'd2; w_in = 16'hAAAA; src0 = 3'd2;
      expect_now(S_OP0,    16'h2222, "cw_no_bypass");
      expect_now(S_OP0_NB, 16'h2222, "cw_nb_old");
      for (int j = 0; j < 8; j++) begin
         step();
         clr = 1'b0; mem = 1'b0;
         expect_now(S_BUSY, 16'h0001, $sformatf("cw_busy_%0d", j));
         expect_now(S_OP0, (j < 3) ? 16'h2222 : 16'h0000, $sformatf("cw_r2_%0d", j));
      end
      step();
      expect_now(S_BUSY, 16'h0000, "cw_done");
      expect_now(S_OP0,  16'h0000, "cw_after");

      // Reset in the middle of a sweep
      mem = 1'b1; dest = 3'd5; w_in = 16'h5A5A;
      step();
      dest = 3'd6; w_in = 16'h6B6B;
      step();
      mem = 1'b0; clr = 1'b1; src0 = 3'd5; src1 = 3'd6;
      expect_now(S_OP0, 16'h5A5A, "rm_pre_r5");
      step();
      clr = 1'b0;
      step();
      expect_now(S_BUSY, 16'h0001, "rm_busy");
      expect_now(S_OP0,  16'h5A5A, "rm_r5_live");
      expect_now(S_OP1,  16'h6B6B, "rm_r6_live");
      step();
      #1;
      reset = 1'b1; mem = 1'b1; dest = 3'd5; w_in = 16'h7777;
      expect_now(S_BUSY,   16'h0000, "rm_busy_drop");
      expect_now(S_OP0,    16'h0000, "rm_op0_zero");
      expect_now(S_OP1,    16'h0000, "rm_op1_zero");
      expect_now(S_OP0_NB, 16'h0000, "rm_nb_zero");
      step();
      expect_now(S_BUSY, 16'h0000, "rm_busy_held");
      expect_now(S_OP0,  16'h0000, "rm_op0_held");
      step();
      reset = 1'b0;
      expect_now(S_BUSY,   16'h0000, "rm_idle");
      expect_now(S_OP0,    16'h7777, "rm_post_bypass");
      expect_now(S_OP0_NB, 16'h0000, "rm_post_nb_old");
      expect_now(S_OP1,    16'h0000, "rm_r6_cleared");
      step();
      mem = 1'b0;
      expect_now(S_OP0,    16'h7777, "rm_post_write");
      expect_now(S_OP0_NB, 16'h7777, "rm_post_nb_write");

      step();
      step();
      while (sb.size() > 0) begin
         m_e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: expectation for cycle %0d never checked", m_e.name, m_e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
